// File: rtl/arb8way16_pkg.sv
// Shared definitions for the 8-way 16-bit round-robin bus arbiter.
// State encoding is fixed so external debug tooling can decode it.
package arb8way16_pkg;
    localparam int NUM_REQ = 8;
    localparam int BUS_W   = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;
endpackage

// File: rtl/arb8way16_rr_pick8.sv
// Combinational round-robin finder: first set req bit scanning upward
// from (ptr+1) mod 8 with wraparound.
module rr_pick8 (
    input  logic [7:0] req,
    input  logic [2:0] ptr,
    output logic       any,
    output logic [2:0] idx
);
    logic       found;
    logic [2:0] pos;

    always_comb begin
        any   = |req;
        idx   = 3'd0;
        found = 1'b0;
        pos   = 3'd0;
        // i=8 wraps to ptr itself, giving the last owner lowest priority
        for (int i = 1; i <= 8; i++) begin
            pos = ptr + 3'(i);
            if (!found && req[pos]) begin
                idx   = pos;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/dmux8way.sv
// 1-to-8 demultiplexer library cell; unselected outputs are 0.
module dmux8way (
    input  logic       in,
    input  logic [2:0] sel,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       d,
    output logic       e,
    output logic       f,
    output logic       g,
    output logic       h
);
    assign a = in & (sel == 3'd0);
    assign b = in & (sel == 3'd1);
    assign c = in & (sel == 3'd2);
    assign d = in & (sel == 3'd3);
    assign e = in & (sel == 3'd4);
    assign f = in & (sel == 3'd5);
    assign g = in & (sel == 3'd6);
    assign h = in & (sel == 3'd7);
endmodule

// File: rtl/mux8way16.sv
// 8-way 16-bit multiplexer library cell.
module mux8way16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic [15:0] d,
    input  logic [15:0] e,
    input  logic [15:0] f,
    input  logic [15:0] g,
    input  logic [15:0] h,
    input  logic [2:0]  sel,
    output logic [15:0] out
);
    always_comb begin
        case (sel)
            3'd0:    out = a;
            3'd1:    out = b;
            3'd2:    out = c;
            3'd3:    out = d;
            3'd4:    out = e;
            3'd5:    out = f;
            3'd6:    out = g;
            default: out = h;
        endcase
    end
endmodule

// File: rtl/arb8way16.sv
// Round-robin arbiter sharing one 16-bit bus among 8 requesters, with a
// bounded hold time and a one-cycle turnaround gap between owners.
module arb8way16
    import arb8way16_pkg::*;
#(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  req,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [15:0] c,
    input  logic [15:0] d,
    input  logic [15:0] e,
    input  logic [15:0] f,
    input  logic [15:0] g,
    input  logic [15:0] h,
    output logic [15:0] bus_out,
    output logic        bus_valid,
    output logic [7:0]  grant,
    output logic [2:0]  grant_idx
);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t            state, state_nx;
    logic [2:0]        ptr, ptr_nx, idx_nx;
    logic [HOLD_W-1:0] hold, hold_nx;
    logic              pick_any;
    logic [2:0]        pick_idx;
    logic              owner_req, others_req;
    logic [15:0]       mux_word;

    rr_pick8 u_pick (
        .req (req),
        .ptr (ptr),
        .any (pick_any),
        .idx (pick_idx)
    );

    assign owner_req  = req[grant_idx];
    assign others_req = |(req & ~(8'b1 << grant_idx));

    always_comb begin
        state_nx = state;
        ptr_nx   = ptr;
        idx_nx   = grant_idx;
        hold_nx  = hold;
        case (state)
            IDLE, GAP: begin
                if (pick_any) begin
                    state_nx = GRANT;
                    idx_nx   = pick_idx;
                    hold_nx  = '0;
                end else begin
                    state_nx = IDLE;
                end
            end
            GRANT: begin
                if (hold != HOLD_MAX)
                    hold_nx = hold + 1'b1;
                // preemption only matters when someone else is waiting
                if (!owner_req || (hold == HOLD_LAST && others_req)) begin
                    state_nx = GAP;
                    ptr_nx   = grant_idx;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= 3'd7;
            grant_idx <= 3'd0;
            hold      <= '0;
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            grant_idx <= idx_nx;
            hold      <= hold_nx;
        end
    end

    assign bus_valid = (state == GRANT);

    mux8way16 u_mux (
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
        .sel (grant_idx),
        .out (mux_word)
    );

    assign bus_out = bus_valid ? mux_word : 16'h0000;

    dmux8way u_dmux (
        .in  (bus_valid),
        .sel (grant_idx),
        .a(grant[0]), .b(grant[1]), .c(grant[2]), .d(grant[3]),
        .e(grant[4]), .f(grant[5]), .g(grant[6]), .h(grant[7])
    );
endmodule

// File: tb/tb_arb8way16.sv
// Directed bench for arb8way16 (MAX_HOLD=4) with hand-computed expectations.
module tb_arb8way16;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  req;
    logic [15:0] a, b, c, d, e, f, g, h;
    logic [15:0] bus_out;
    logic        bus_valid;
    logic [7:0]  grant;
    logic [2:0]  grant_idx;

    int n_checks = 0;
    int n_errors = 0;

    arb8way16 #(.MAX_HOLD(4), .HOLD_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h),
        .bus_out   (bus_out),
        .bus_valid (bus_valid),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        req   = 8'hFF;
        a = 16'hA000; b = 16'hA001; c = 16'hA002; d = 16'hA003;
        e = 16'hA004; f = 16'hA005; g = 16'hA006; h = 16'hA007;

        // reset held with all requests high
        repeat (3) @(posedge clk);
        #1;
        chk("rst_grant", 16'(grant), 16'h0000);
        chk("rst_valid", 16'(bus_valid), 16'h0000);
        chk("rst_bus", bus_out, 16'h0000);
        chk("rst_idx", 16'(grant_idx), 16'h0000);
        rst_n = 1'b1;
        tick();
        chk("rst_first_grant", 16'(grant), 16'h0001);
        chk("rst_first_bus", bus_out, 16'hA000);
        req = 8'h00;
        tick();
        chk("rst_gap_valid", 16'(bus_valid), 16'h0000);
        tick();
        chk("rst_idle_valid", 16'(bus_valid), 16'h0000);

        // single requester 3
        req = 8'h08;
        d   = 16'hBEEF;
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("single_grant", 16'(grant), 16'h0008);
            chk("single_idx", 16'(grant_idx), 16'h0003);
            chk("single_bus", bus_out, 16'hBEEF);
        end
        req = 8'h00;
        tick();
        chk("single_gap_valid", 16'(bus_valid), 16'h0000);
        chk("single_gap_grant", 16'(grant), 16'h0000);
        chk("single_gap_bus", bus_out, 16'h0000);
        chk("single_gap_idx", 16'(grant_idx), 16'h0003);
        tick();
        chk("single_idle_valid", 16'(bus_valid), 16'h0000);

        // rotation from a fresh pointer
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        req = 8'hFF;
        for (int k = 0; k <= 8; k++) begin
            logic [7:0] ob;
            ob = 8'(1 << (k % 8));
            tick();
            chk("rot_grant_c1", 16'(grant), 16'(ob));
            tick();
            chk("rot_grant_c2", 16'(grant), 16'(ob));
            req = 8'hFF & ~ob;
            tick();
            chk("rot_gap_valid", 16'(bus_valid), 16'h0000);
            req = (k == 8) ? 8'h00 : 8'hFF;
        end
        tick();
        chk("rot_idle_valid", 16'(bus_valid), 16'h0000);

        // preemption after exactly 4 cycles
        req = 8'h04;
        tick();
        chk("pre_grant_c1", 16'(grant), 16'h0004);
        req = 8'h24;
        for (int i = 2; i <= 4; i++) begin
            tick();
            chk("pre_grant_hold", 16'(grant), 16'h0004);
        end
        tick();
        chk("pre_gap_valid", 16'(bus_valid), 16'h0000);
        chk("pre_gap_idx", 16'(grant_idx), 16'h0002);
        tick();
        chk("pre_new_grant", 16'(grant), 16'h0020);
        chk("pre_new_bus", bus_out, 16'hA005);
        req = 8'h04;
        tick();
        chk("pre_gap2_valid", 16'(bus_valid), 16'h0000);
        tick();
        chk("pre_regrant", 16'(grant), 16'h0004);
        req = 8'h00;
        tick();
        tick();
        chk("pre_idle_valid", 16'(bus_valid), 16'h0000);

        // sole requester keeps the bus, data passes through each cycle
        req = 8'h40;
        for (int i = 0; i < 20; i++) begin
            g = 16'h1000 + 16'(i);
            tick();
            chk("alone_grant", 16'(grant), 16'h0040);
            chk("alone_bus", bus_out, 16'h1000 + 16'(i));
        end

        // asynchronous reset in the middle of the grant
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_grant", 16'(grant), 16'h0000);
        chk("mrst_valid", 16'(bus_valid), 16'h0000);
        chk("mrst_bus", bus_out, 16'h0000);
        chk("mrst_idx", 16'(grant_idx), 16'h0000);
        req = 8'h81;
        #1;
        rst_n = 1'b1;
        tick();
        chk("mrst_first_grant", 16'(grant), 16'h0001);
        chk("mrst_first_idx", 16'(grant_idx), 16'h0000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
